// File: rtl/jacobi_sweep_ctrl_pkg.sv
// Shared types and sizing helpers for the Jacobi sweep sequencer.
// Widths depend on the instance parameters, so the helpers are functions.
package jacobi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROT_ISSUE,
        S_ROT_WAIT,
        S_CHK_CLR,
        S_CHK_STREAM,
        S_CHK_DRAIN,
        S_CHK_WAIT,
        S_FINISH
    } sweep_state_t;

    function automatic int n_pairs(input int n);
        return n * (n - 1) / 2;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n * n) : 1;
    endfunction

    function automatic int iter_w(input int m);
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

    localparam int DEF_N_STOCKS = 4;
    localparam int DEF_MAX_ITER = 16;
    localparam int IDX_W  = idx_w(DEF_N_STOCKS);
    localparam int ADDR_W = addr_w(DEF_N_STOCKS);
    localparam int ITER_W = iter_w(DEF_MAX_ITER);

endpackage

// File: rtl/jacobi_sweep_ctrl_pair_sequencer.sv
// Walks the strict upper triangle (p<q) of an N_STOCKS x N_STOCKS matrix, row by row.
module pair_sequencer #(
    parameter int N_STOCKS = 4,
    parameter int IDX_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    output logic [IDX_W-1:0] p_o,
    output logic [IDX_W-1:0] q_o,
    output logic             last_o
);

    logic [IDX_W-1:0] p_q, p_d, q_q, q_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
            q_q <= '0;
        end else begin
            p_q <= p_d;
            q_q <= q_d;
        end
    end

    always_comb begin
        p_d = p_q;
        q_d = q_q;
        if (load_i) begin
            p_d = '0;
            q_d = IDX_W'(1);
        end else if (step_i) begin
            // End of a row: next row starts just right of the diagonal.
            if (q_q == IDX_W'(N_STOCKS - 1)) begin
                p_d = p_q + IDX_W'(1);
                q_d = p_q + IDX_W'(2);
            end else begin
                q_d = q_q + IDX_W'(1);
            end
        end
    end

    assign p_o    = p_q;
    assign q_o    = q_q;
    assign last_o = (p_q == IDX_W'(N_STOCKS - 2)) && (q_q == IDX_W'(N_STOCKS - 1));

endmodule

// File: rtl/jacobi_sweep_ctrl.sv
// Jacobi sweep sequencer: rotation requests per off-diagonal pair, then a full
// matrix stream into the convergence checker, repeated until converged or timed out.
module jacobi_sweep_ctrl
    import jacobi_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int N_STOCKS = 4,
    parameter int MAX_ITER = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    output logic                              busy,
    output logic                              done,
    output logic                              converged,
    output logic                              timeout,
    output logic [iter_w(MAX_ITER)-1:0]       iter_count,
    output logic                              rot_start,
    output logic [idx_w(N_STOCKS)-1:0]        rot_p,
    output logic [idx_w(N_STOCKS)-1:0]        rot_q,
    input  logic                              rot_done,
    output logic                              mem_rd_en,
    output logic [addr_w(N_STOCKS)-1:0]       mem_rd_addr,
    input  logic [WIDTH-1:0]                  mem_rd_data,
    output logic                              chk_rst,
    output logic                              chk_valid,
    output logic [WIDTH-1:0]                  chk_data,
    input  logic                              chk_res_valid,
    input  logic                              chk_res
);

    localparam int IW = idx_w(N_STOCKS);
    localparam int AW = addr_w(N_STOCKS);
    localparam int TW = iter_w(MAX_ITER);

    sweep_state_t  state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [TW-1:0] iter_q, iter_d;
    logic          conv_q, conv_d;
    logic          tout_q, tout_d;
    logic          cvld_q, cvld_d;
    logic          pair_load, pair_step, pair_last;

    pair_sequencer #(
        .N_STOCKS (N_STOCKS),
        .IDX_W    (IW)
    ) u_pairs (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (pair_load),
        .step_i (pair_step),
        .p_o    (rot_p),
        .q_o    (rot_q),
        .last_o (pair_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            iter_q  <= '0;
            conv_q  <= 1'b0;
            tout_q  <= 1'b0;
            cvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            iter_q  <= iter_d;
            conv_q  <= conv_d;
            tout_q  <= tout_d;
            cvld_q  <= cvld_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        iter_d    = iter_q;
        conv_d    = conv_q;
        tout_d    = tout_q;
        cvld_d    = (state_q == S_CHK_STREAM);
        pair_load = 1'b0;
        pair_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d   = S_ROT_ISSUE;
                    conv_d    = 1'b0;
                    tout_d    = 1'b0;
                    iter_d    = '0;
                    pair_load = 1'b1;
                end
            end
            S_ROT_ISSUE: state_d = S_ROT_WAIT;
            S_ROT_WAIT: begin
                if (rot_done) begin
                    if (pair_last) begin
                        state_d = S_CHK_CLR;
                    end else begin
                        pair_step = 1'b1;
                        state_d   = S_ROT_ISSUE;
                    end
                end
            end
            S_CHK_CLR: begin
                addr_d  = '0;
                state_d = S_CHK_STREAM;
            end
            S_CHK_STREAM: begin
                addr_d = addr_q + AW'(1);
                if (addr_q == AW'(N_STOCKS * N_STOCKS - 1)) state_d = S_CHK_DRAIN;
            end
            S_CHK_DRAIN: state_d = S_CHK_WAIT;
            S_CHK_WAIT: begin
                if (chk_res_valid) begin
                    iter_d = iter_q + TW'(1);
                    if (chk_res) begin
                        conv_d  = 1'b1;
                        state_d = S_FINISH;
                    end else if (int'(iter_q) + 1 == MAX_ITER) begin
                        tout_d  = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        pair_load = 1'b1;
                        state_d   = S_ROT_ISSUE;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Abort drops everything in flight but keeps the completed-sweep count.
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            conv_d    = 1'b0;
            tout_d    = 1'b0;
            cvld_d    = 1'b0;
            iter_d    = iter_q;
            pair_load = 1'b0;
            pair_step = 1'b0;
        end
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_FINISH);
        rot_start   = (state_q == S_ROT_ISSUE);
        chk_rst     = (state_q == S_CHK_CLR);
        mem_rd_en   = (state_q == S_CHK_STREAM);
        mem_rd_addr = addr_q;
        chk_valid   = cvld_q;
        chk_data    = cvld_q ? mem_rd_data : '0;
        converged   = conv_q;
        timeout     = tout_q;
        iter_count  = iter_q;
    end

endmodule

// File: tb/tb_jacobi_sweep_ctrl.sv
// Directed bench for jacobi_sweep_ctrl with rotation-engine, matrix-RAM and checker models.
module tb_jacobi_sweep_ctrl;

    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int MI    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic             busy, done, converged, timeout, rot_start, mem_rd_en, chk_rst, chk_valid;
    logic [1:0]       iter_count, rot_p, rot_q;
    logic [3:0]       mem_rd_addr;
    logic [WIDTH-1:0] mem_rd_data = '0, chk_data;
    logic             rot_done, chk_res_valid, chk_res;

    logic rot_done_m = 1'b0, rot_spur = 1'b0;
    logic chk_vm = 1'b0, chk_spur = 1'b0, chk_res_m = 1'b0, res_val = 1'b0;

    assign rot_done      = rot_done_m | rot_spur;
    assign chk_res_valid = chk_vm | chk_spur;
    assign chk_res       = chk_spur ? 1'b1 : chk_res_m;

    jacobi_sweep_ctrl #(.WIDTH(WIDTH), .N_STOCKS(N), .MAX_ITER(MI)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .converged(converged), .timeout(timeout),
        .iter_count(iter_count), .rot_start(rot_start), .rot_p(rot_p), .rot_q(rot_q),
        .rot_done(rot_done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .chk_rst(chk_rst), .chk_valid(chk_valid),
        .chk_data(chk_data), .chk_res_valid(chk_res_valid), .chk_res(chk_res)
    );

    // Synchronous matrix RAM: element value = addr*7
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= WIDTH'(int'(mem_rd_addr) * 7);

    int cyc = 0, rcnt = 0, wcnt = 0;
    int rot_hi = 0, rot_rise = 0, chkrst_cnt = 0, done_cnt = 0, stab_err = 0;
    int rot_pair_q[$], rd_addr_q[$], rd_cyc_q[$], vld_cyc_q[$], beat_q[$];
    logic prev_rs = 1'b0, pv = 1'b0, inflight = 1'b0;
    logic [1:0] cur_p = '0, cur_q = '0;

    // Monitor first, then rotation engine and checker models
    always @(negedge clk) begin
        cyc++;
        if (rot_start) begin
            rot_hi++;
            if (!prev_rs) rot_rise++;
            rot_pair_q.push_back(int'(rot_p) * 4 + int'(rot_q));
            cur_p = rot_p; cur_q = rot_q; inflight = 1'b1;
        end else if (inflight) begin
            if (rot_p !== cur_p || rot_q !== cur_q) stab_err++;
            if (rot_done_m) inflight = 1'b0;
        end
        prev_rs = rot_start;
        if (chk_rst) chkrst_cnt++;
        if (done) done_cnt++;
        if (mem_rd_en) begin rd_addr_q.push_back(int'(mem_rd_addr)); rd_cyc_q.push_back(cyc); end
        if (chk_valid) begin beat_q.push_back(int'(chk_data)); vld_cyc_q.push_back(cyc); end

        rot_done_m = 1'b0;
        if (rcnt > 0) begin rcnt--; if (rcnt == 0) rot_done_m = 1'b1; end
        if (rot_start) rcnt = 3;

        chk_vm = 1'b0;
        if (wcnt > 0) begin
            wcnt--;
            if (wcnt == 0) begin chk_vm = 1'b1; chk_res_m = res_val; end
        end
        if (pv && !chk_valid) wcnt = 2;
        pv = chk_valid;
    end

    int n_cmp = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {24'd0, busy, done, converged, timeout, rot_start, mem_rd_en, chk_rst, chk_valid}, 0);
        check({tag, "_iter"}, 32'(iter_count), 0);
        check({tag, "_pq"}, {28'd0, rot_p, rot_q}, 0);
        check({tag, "_addr"}, 32'(mem_rd_addr), 0);
        check({tag, "_data"}, 32'(chk_data), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles from the first ROT_ISSUE to the done pulse; optional mid-stream disturbance.
    task automatic run_wait(input bit inject, output int cycles, output bit ok);
        bit injd = 1'b0;
        cycles = 0; ok = 1'b0;
        while (cycles < 400 && !ok) begin
            if (done) ok = 1'b1;
            else begin
                if (inject && !injd && mem_rd_en) begin
                    rot_spur = 1'b1; chk_spur = 1'b1; start = 1'b1; injd = 1'b1;
                end else begin
                    rot_spur = 1'b0; chk_spur = 1'b0; start = 1'b0;
                end
                @(negedge clk);
                cycles++;
            end
        end
        rot_spur = 1'b0; chk_spur = 1'b0; start = 1'b0;
    endtask

    int exp_pairs[6] = '{1, 2, 3, 6, 7, 11};
    int b_pair, b_rd, b_vld, b_rot, b_rise, b_rst, b_done, cycles, k;
    bit ok;

    task automatic snap();
        b_pair = rot_pair_q.size(); b_rd = rd_addr_q.size(); b_vld = vld_cyc_q.size();
        b_rot = rot_hi; b_rise = rot_rise; b_rst = chkrst_cnt; b_done = done_cnt;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1/3: converges after one sweep
        res_val = 1'b1; snap();
        pulse_start();
        run_wait(1'b0, cycles, ok);
        check("t1_done_seen", 32'(ok), 1);
        check("t1_cycles", cycles, 45);
        check("t1_flags", {29'd0, busy, converged, timeout}, 3'b110);
        check("t1_iter", 32'(iter_count), 1);
        @(negedge clk); #1;
        check("t1_idle", {30'd0, busy, done}, 0);
        check("t1_hold", {29'd0, converged, timeout, iter_count == 2'd1}, 3'b101);
        check("t1_rot_cycles", rot_hi - b_rot, 6);
        check("t1_rot_pulses", rot_rise - b_rise, 6);
        for (int i = 0; i < 6; i++) check("t1_pair", rot_pair_q[b_pair + i], exp_pairs[i]);
        check("t1_chk_rst", chkrst_cnt - b_rst, 1);
        check("t1_done_cnt", done_cnt - b_done, 1);
        check("t1_rd_beats", rd_addr_q.size() - b_rd, 16);
        check("t1_vld_beats", vld_cyc_q.size() - b_vld, 16);
        check("t1_first_lat", vld_cyc_q[b_vld] - rd_cyc_q[b_rd], 1);
        check("t1_rd_contig", rd_cyc_q[b_rd + 15] - rd_cyc_q[b_rd], 15);
        check("t1_vld_contig", vld_cyc_q[b_vld + 15] - vld_cyc_q[b_vld], 15);
        for (int i = 0; i < 16; i++) begin
            check("t1_addr", rd_addr_q[b_rd + i], i);
            check("t3_data", beat_q[b_vld + i], i * 7);
        end
        check("t1_stable", stab_err, 0);

        // Test 2: never converges, times out after 3 sweeps
        res_val = 1'b0; snap();
        pulse_start();
        run_wait(1'b0, cycles, ok);
        check("t2_done_seen", 32'(ok), 1);
        check("t2_cycles", cycles, 135);
        check("t2_flags", {30'd0, converged, timeout}, 2'b01);
        check("t2_iter", 32'(iter_count), 3);
        @(negedge clk); #1;
        check("t2_rot", rot_hi - b_rot, 18);
        check("t2_chk_rst", chkrst_cnt - b_rst, 3);
        check("t2_done_cnt", done_cnt - b_done, 1);
        check("t2_vld_beats", vld_cyc_q.size() - b_vld, 48);

        // Test 4: abort in ROT_WAIT of the 3rd pair of sweep 2
        res_val = 1'b0;
        pulse_start();
        k = 0; cycles = 0;
        while (cycles < 300) begin
            if (rot_start) k++;
            if (k == 9) break;
            @(negedge clk);
            cycles++;
        end
        check("t4_reach_9th", k, 9);
        check("t4_pair", {28'd0, rot_p, rot_q}, 4'b0011);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_busy", 32'(busy), 0);
        check("t4_outs", {28'd0, done, rot_start, chk_valid, chk_rst}, 0);
        check("t4_flags", {30'd0, converged, timeout}, 0);
        check("t4_iter", 32'(iter_count), 1);
        #1; snap();
        repeat (10) @(negedge clk);
        #1;
        check("t4_no_done", done_cnt - b_done, 0);
        check("t4_no_rot", rot_hi - b_rot, 0);
        check("t4_still_idle", 32'(busy), 0);
        res_val = 1'b1;
        @(negedge clk);
        pulse_start();
        check("t4_restart_iter", 32'(iter_count), 0);
        check("t4_restart_pq", {27'd0, rot_start, rot_p, rot_q}, 5'b10001);
        run_wait(1'b0, cycles, ok);
        check("t4_rerun", {cycles, 31'd0, ok}, {32'd45, 32'd1});
        check("t4_rerun_iter", {29'd0, converged, iter_count}, 3'b101);
        @(negedge clk);

        // Test 5: spurious inputs in IDLE and CHK_STREAM, start while busy
        rot_spur = 1'b1; chk_spur = 1'b1;
        @(negedge clk);
        rot_spur = 1'b0; chk_spur = 1'b0;
        @(negedge clk);
        check("t5_idle_stay", {30'd0, busy, done}, 0);
        res_val = 1'b1; #1; snap();
        pulse_start();
        run_wait(1'b1, cycles, ok);
        check("t5_done_seen", 32'(ok), 1);
        check("t5_cycles", cycles, 45);
        check("t5_flags", {29'd0, converged, timeout, iter_count == 2'd1}, 3'b101);
        @(negedge clk); #1;
        check("t5_rot", rot_hi - b_rot, 6);
        check("t5_vld_beats", vld_cyc_q.size() - b_vld, 16);
        check("t5_done_cnt", done_cnt - b_done, 1);

        // Test 6: asynchronous reset mid CHK_STREAM
        res_val = 1'b0;
        @(negedge clk);
        pulse_start();
        cycles = 0;
        while (!mem_rd_en && cycles < 100) begin @(negedge clk); cycles++; end
        check("t6_reach_stream", 32'(mem_rd_en), 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_quiet("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        res_val = 1'b1;
        pulse_start();
        run_wait(1'b0, cycles, ok);
        check("t6_done_seen", 32'(ok), 1);
        check("t6_cycles", cycles, 45);
        check("t6_flags", {29'd0, converged, timeout, iter_count == 2'd1}, 3'b101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
